// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle base ops plus a bit-serial M-extension unit
// (shift-add multiply, restoring divide on operand magnitudes).
// Build option: define ITER_ALU_MULDIV_EN to include the multiply/divide
// datapath; without it, M-extension requests return the 0xDEADBEEF pattern.

package iter_alu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SRL  = 4'd3,
      ALU_SRA  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_XOR  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10
   } aluFunc_t;
endpackage

module iter_alu
   import iter_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  aluFunc_t         alu_fun,
   input  logic             md_en,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             kill,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [63:0]      POISON64 = {2{32'hDEADBEEF}};
   localparam logic [WIDTH-1:0] POISON   = POISON64[WIDTH-1:0];

   state_t           state_q, state_d;
   logic             accept;
   logic             ld_res;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] base_res;
   logic [SHW-1:0]   shamt;

   assign in_ready  = (state_q != CALC);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid & in_ready & ~kill;
   assign shamt     = srcB[SHW-1:0];

   // Single-cycle base operations, evaluated straight from the inputs
   always_comb begin
      base_res = POISON;
      case (alu_fun)
         ALU_ADD:  base_res = srcA + srcB;
         ALU_SUB:  base_res = srcA - srcB;
         ALU_SLL:  base_res = srcA << shamt;
         ALU_SRL:  base_res = srcA >> shamt;
         ALU_SRA:  base_res = $signed(srcA) >>> shamt;
         ALU_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
         ALU_SLTU: base_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
         ALU_XOR:  base_res = srcA ^ srcB;
         ALU_OR:   base_res = srcA | srcB;
         ALU_AND:  base_res = srcA & srcB;
         ALU_LUI:  base_res = srcA;
         default:  base_res = POISON;
      endcase
   end

`ifdef ITER_ALU_MULDIV_EN
   localparam int unsigned   CW      = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0]   hi_q, lo_q, opb_q;
   logic [CW-1:0]      cnt_q;
   logic [2:0]         op_q;
   logic               neg_q, neg_r;
   logic               start_md, step_md, cnt_last;
   logic               is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
   logic [WIDTH-1:0]   mag_a, mag_b, special_res;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic [WIDTH-1:0]   hi_n, lo_n, quo, rem, md_res;
   logic [2*WIDTH-1:0] prod, prod_s;

   assign busy     = (state_q == CALC);
   assign cnt_last = (cnt_q == CW'(WIDTH-1));

   // Operand decode at accept: signedness, magnitudes and one-cycle special cases
   always_comb begin
      is_div      = md_op[2];
      sgn_a       = is_div ? ~md_op[0] : (md_op[1:0] == 2'b01 || md_op[1:0] == 2'b10);
      sgn_b       = is_div ? ~md_op[0] : (md_op[1:0] == 2'b01);
      a_neg       = sgn_a & srcA[WIDTH-1];
      b_neg       = sgn_b & srcB[WIDTH-1];
      mag_a       = a_neg ? -srcA : srcA;
      mag_b       = b_neg ? -srcB : srcB;
      div_zero    = is_div & (srcB == '0);
      div_ovf     = is_div & ~md_op[0] & (srcA == MIN_NEG) & (srcB == '1);
      special_res = div_zero ? (md_op[1] ? srcA : '1) : (md_op[1] ? '0 : srcA);
   end

   // One iteration of shift-add multiply or restoring divide, plus sign fix-up
   // of the final value (only consumed on the last iteration)
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opb_q};
      if (op_q[2]) begin
         if (!div_trial[WIDTH]) begin
            hi_n = div_trial[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_n = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_n = mul_sum[WIDTH:1];
         lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      prod   = {hi_n, lo_n};
      prod_s = neg_q ? -prod : prod;
      quo    = neg_q ? -lo_n : lo_n;
      rem    = neg_r ? -hi_n : hi_n;
      if (op_q[2])
         md_res = op_q[1] ? rem : quo;
      else
         md_res = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
   end

   // Iterative datapath registers: load on start, advance one bit per CALC cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         opb_q <= '0;
         cnt_q <= '0;
         op_q  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (start_md) begin
         hi_q  <= '0;
         lo_q  <= is_div ? mag_a : mag_b;
         opb_q <= is_div ? mag_b : mag_a;
         cnt_q <= '0;
         op_q  <= md_op;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
      end else if (step_md) begin
         hi_q  <= hi_n;
         lo_q  <= lo_n;
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   logic unused_md;

   assign busy      = 1'b0;
   assign unused_md = ^md_op;
`endif

   // Next-state and result-load decisions
   always_comb begin
      state_d = state_q;
      ld_res  = 1'b0;
      res_d   = result;
`ifdef ITER_ALU_MULDIV_EN
      start_md = 1'b0;
      step_md  = 1'b0;
`endif
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               state_d = DONE;
               ld_res  = 1'b1;
               if (!md_en) begin
                  res_d = base_res;
               end
`ifdef ITER_ALU_MULDIV_EN
               else if (div_zero || div_ovf) begin
                  res_d = special_res;
               end else begin
                  state_d  = CALC;
                  ld_res   = 1'b0;
                  start_md = 1'b1;
               end
`else
               else begin
                  res_d = POISON;
               end
`endif
            end
         end
`ifdef ITER_ALU_MULDIV_EN
         CALC: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               step_md = 1'b1;
               if (cnt_last) begin
                  state_d = DONE;
                  ld_res  = 1'b1;
                  res_d   = md_res;
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Result register, written only on the edge that enters DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      result <= '0;
      else if (ld_res) result <= res_d;
   end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (WIDTH=32): directed vector table,
// randomized ops against an arithmetic reference model, and hand-written
// sequences for kill, back-to-back issue and asynchronous reset.
module tb_iter_alu;
   import iter_alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         md_en = 1'b0;
   logic         kill = 1'b0;
   logic [2:0]   md_op = 3'd0;
   aluFunc_t     alu_fun = ALU_ADD;
   logic [W-1:0] srcA = '0;
   logic [W-1:0] srcB = '0;
   logic         in_ready, out_valid, busy;
   logic [W-1:0] result;

   int n_pass  = 0;
   int n_total = 0;

   iter_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_fun   (alu_fun),
      .md_en     (md_en),
      .md_op     (md_op),
      .srcA      (srcA),
      .srcB      (srcB),
      .kill      (kill),
      .out_valid (out_valid),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // result may only move on an out_valid cycle; also track busy activity
   logic [W-1:0] mon_last;
   int mon_viol = 0;
   int busy_hi  = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_last = '0;
      end else begin
         if (result !== mon_last && !out_valid) mon_viol++;
         mon_last = result;
         if (busy) busy_hi++;
      end
   end

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, got, exp);
   endtask

   // Reference model: plain integer arithmetic on the operation's definition
   task automatic model(input logic md, input logic [2:0] op, input aluFunc_t f,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output int lat);
      longint sa, sb;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lat = 1;
      r   = 32'hDEADBEEF;
      if (!md) begin
         case (f)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = 32'(sa >>> b[4:0]);
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_LUI:  r = a;
            default:  r = 32'hDEADBEEF;
         endcase
      end else begin
`ifdef ITER_ALU_MULDIV_EN
         lat = W + 1;
         case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'd0, b})); r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: if (b == 0) begin r = '1; lat = 1; end
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = a; lat = 1; end
                  else r = 32'(sa / sb);
            3'd5: if (b == 0) begin r = '1; lat = 1; end
                  else r = a / b;
            3'd6: if (b == 0) begin r = a; lat = 1; end
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = '0; lat = 1; end
                  else r = 32'(sa % sb);
            default: if (b == 0) begin r = a; lat = 1; end
                     else r = a % b;
         endcase
`endif
      end
   endtask

   // Issue one request, then count cycles until out_valid (bounded)
   task automatic run_op(input logic md, input logic [2:0] op, input aluFunc_t f,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output int lat, output int bcyc);
      @(negedge clk);
      check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
      md_en = md; md_op = op; alu_fun = f; srcA = a; srcB = b; kill = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = -1; bcyc = 0; res = 'x;
      for (int k = 1; k <= 200; k++) begin
         if (out_valid) begin
            lat = k;
            res = result;
            break;
         end
         if (busy) bcyc++;
         @(posedge clk);
         #1;
      end
   endtask

   typedef struct packed {
      logic         md;
      logic [2:0]   op;
      aluFunc_t     f;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int           lat;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic md, input logic [2:0] op, input aluFunc_t f,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp, input int lat);
      vec_t v;
      v.md = md; v.op = op; v.f = f; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
      vecs.push_back(v);
   endtask

   initial begin
      logic [W-1:0] got, exp;
      int lat, elat, bcyc, cnt;
      logic md;
      logic [2:0] op;
      aluFunc_t f;
      logic [W-1:0] a, b;

      // directed vectors
      add(0, 0, ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
      add(0, 0, ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1);
      add(0, 0, ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1);
      add(0, 0, ALU_SLL,  32'h00000001, 32'h0000003F, 32'h80000000, 1);
      add(0, 0, ALU_SRL,  32'h80000000, 32'h00000021, 32'h40000000, 1);
      add(0, 0, ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
      add(0, 0, ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
      add(0, 0, ALU_XOR,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1);
      add(0, 0, ALU_OR,   32'hF0000000, 32'h0000000F, 32'hF000000F, 1);
      add(0, 0, ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
      add(0, 0, ALU_LUI,  32'h12345000, 32'hFFFFFFFF, 32'h12345000, 1);
      add(0, 0, aluFunc_t'(4'd12), 32'h1, 32'h2, 32'hDEADBEEF, 1);
`ifdef ITER_ALU_MULDIV_EN
      add(1, 3'd3, ALU_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      add(1, 3'd1, ALU_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
      add(1, 3'd2, ALU_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      add(1, 3'd0, ALU_ADD, 32'd3,        32'd5,        32'd15,       33);
      add(1, 3'd4, ALU_ADD, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      add(1, 3'd6, ALU_ADD, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      add(1, 3'd5, ALU_ADD, 32'd7,        32'd0,        32'hFFFFFFFF, 1);
      add(1, 3'd7, ALU_ADD, 32'd7,        32'd0,        32'd7,        1);
      add(1, 3'd6, ALU_ADD, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
      add(1, 3'd4, ALU_ADD, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
`else
      add(1, 3'd0, ALU_ADD, 32'd3,        32'd5,        32'hDEADBEEF, 1);
      add(1, 3'd4, ALU_ADD, 32'hFFFFFFF9, 32'd2,        32'hDEADBEEF, 1);
`endif

      // reset state
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_busy",      {31'd0, busy},      32'd0);
      check("reset_result",    result,             32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

      foreach (vecs[i]) begin
         run_op(vecs[i].md, vecs[i].op, vecs[i].f, vecs[i].a, vecs[i].b, got, lat, bcyc);
         check($sformatf("vec%0d_result", i),  got,         vecs[i].exp);
         check($sformatf("vec%0d_latency", i), 32'(lat),    32'(vecs[i].lat));
         check($sformatf("vec%0d_busy", i),    32'(bcyc),   (vecs[i].lat > 1) ? 32'(W) : 32'd0);
      end

      // randomized ops against the model
      for (int i = 0; i < 60; i++) begin
         md = 1'($urandom_range(0, 1));
         op = 3'($urandom_range(0, 7));
         f  = aluFunc_t'(4'($urandom_range(0, 15)));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 9))
            0: b = '0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = 32'($urandom_range(1, 9));
            3: a = 32'h80000000;
            default: ;
         endcase
         model(md, op, f, a, b, exp, elat);
         run_op(md, op, f, a, b, got, lat, bcyc);
         check($sformatf("rand%0d_result", i),  got,      exp);
         check($sformatf("rand%0d_latency", i), 32'(lat), 32'(elat));
      end

      // kill while DONE with a pending request: not accepted
      run_op(0, 0, ALU_ADD, 32'd1, 32'd2, got, lat, bcyc);
      check("seed_result", got, 32'd3);
      @(negedge clk);
      md_en = 1'b0; alu_fun = ALU_ADD; srcA = 32'd5; srcB = 32'd5;
      in_valid = 1'b1; kill = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; kill = 1'b0;
      check("kill_idle_out_valid", {31'd0, out_valid}, 32'd0);
      check("kill_idle_result",    result,             32'd3);

`ifdef ITER_ALU_MULDIV_EN
      // kill in the 5th CALC cycle of a DIVU
      @(negedge clk);
      md_en = 1'b1; md_op = 3'd5; srcA = 32'd1000; srcB = 32'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("kill_calc_busy_first", {31'd0, busy}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      check("kill_calc_busy_fifth", {31'd0, busy}, 32'd1);
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill_calc_busy",      {31'd0, busy},      32'd0);
      check("kill_calc_in_ready",  {31'd0, in_ready},  32'd1);
      check("kill_calc_out_valid", {31'd0, out_valid}, 32'd0);
      check("kill_calc_result",    result,             32'd3);
      cnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) cnt++;
      end
      check("kill_calc_no_late_valid", 32'(cnt), 32'd0);
`endif

      // back-to-back base ops with in_valid held high
      @(negedge clk);
      md_en = 1'b0; alu_fun = ALU_ADD; srcA = 32'd10; srcB = 32'd20;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("b2b_1_valid",  {31'd0, out_valid}, 32'd1);
      check("b2b_1_result", result,             32'd30);
      alu_fun = ALU_SUB; srcA = 32'd50; srcB = 32'd8;
      @(posedge clk);
      #1;
      check("b2b_2_valid",  {31'd0, out_valid}, 32'd1);
      check("b2b_2_result", result,             32'd42);
      alu_fun = ALU_XOR; srcA = 32'h0000F0F0; srcB = 32'h00000FF0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("b2b_3_valid",  {31'd0, out_valid}, 32'd1);
      check("b2b_3_result", result,             32'h0000FF00);
      @(posedge clk);
      #1;
      check("b2b_drop_valid", {31'd0, out_valid}, 32'd0);
      check("b2b_hold_result", result,            32'h0000FF00);

      // asynchronous reset, mid-CALC when the M unit exists
`ifdef ITER_ALU_MULDIV_EN
      @(negedge clk);
      md_en = 1'b1; md_op = 3'd0; srcA = 32'd3; srcB = 32'd5;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_async_busy",      {31'd0, busy},      32'd0);
      check("rst_async_result",    result,             32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_release_busy",     {31'd0, busy},     32'd0);

      check("result_only_on_valid", 32'(mon_viol), 32'd0);
`ifndef ITER_ALU_MULDIV_EN
      check("busy_never_high", 32'(busy_hi), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
